// File: rtl/dct_quant_zigzag_if.sv
// Serial output stream of the DCT quantizer: quantized coefficient, its zigzag
// position and a valid/ready handshake.
interface dct_quant_zigzag_if #(
    parameter int OW = 12
);
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_pos;
    logic          out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_pos,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_pos,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/dct_quant_zigzag.sv
// Captures a parallel 8x8 DCT block, quantizes each coefficient by a reciprocal
// multiply and streams the results out in JPEG zigzag order.
module dct_quant_zigzag #(
    parameter int W  = 20,
    parameter int OW = 12,
    parameter int RW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [64*W-1:0]      coef_in,
    input  logic                 in_valid,
    input  logic [64*RW-1:0]     qtab,
    dct_quant_zigzag_if.master   out_if,
    output logic                 block_done,
    output logic                 busy,
    output logic                 overrun
);

    localparam int PW = W + RW + 1;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic signed [PW-1:0] HALF = {{(W+1){1'b0}}, 1'b1, {(RW-1){1'b0}}};
    localparam logic signed [W:0]    QMAX = {{(W-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [W:0]    QMIN = {{(W-OW+2){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_e;

    state_e          state_q;
    logic [5:0]      k_q;
    logic            in_valid_q;
    logic [OW-1:0]   out_data_q;
    logic            out_valid_q;
    logic            block_done_q;
    logic            overrun_q;
    logic [W-1:0]    coef_buf_q [64];

    logic                 start;
    logic                 handshake;
    logic [5:0]           qidx_d;
    logic [5:0]           zz_idx;
    logic [RW-1:0]        recip;
    logic signed [PW-1:0] coef_ext;
    logic signed [PW-1:0] recip_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rounded;
    logic signed [W:0]    scaled;
    logic [OW-1:0]        quant_d;

    assign start     = in_valid & ~in_valid_q;
    assign handshake = out_valid_q & out_if.out_ready;

    // In LOAD the first output is prepared; in SEND the one after the current k.
    always_comb begin
        qidx_d    = (state_q == LOAD) ? 6'd0 : k_q + 6'd1;
        zz_idx    = ZZ[qidx_d];
        recip     = qtab[int'(zz_idx)*RW +: RW];
        coef_ext  = {{(RW+1){coef_buf_q[zz_idx][W-1]}}, coef_buf_q[zz_idx]};
        recip_ext = {{(W+1){1'b0}}, recip};
        prod      = coef_ext * recip_ext;
        rounded   = prod + HALF;
        scaled    = rounded[PW-1:RW];
        quant_d   = scaled[OW-1:0];
        if (scaled > QMAX) begin
            quant_d = QMAX[OW-1:0];
        end else if (scaled < QMIN) begin
            quant_d = QMIN[OW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            for (int i = 0; i < 64; i++) begin
                coef_buf_q[i] <= coef_in[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            k_q          <= 6'd0;
            in_valid_q   <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            block_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            in_valid_q   <= in_valid;
            block_done_q <= 1'b0;
            if (start && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        k_q     <= 6'd0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    out_data_q  <= quant_d;
                    out_valid_q <= 1'b1;
                    state_q     <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        if (k_q == 6'd63) begin
                            out_valid_q  <= 1'b0;
                            block_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            k_q        <= k_q + 6'd1;
                            out_data_q <= quant_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_pos   = k_q;
    assign out_if.out_last  = out_valid_q && (k_q == 6'd63);
    assign block_done       = block_done_q;
    assign busy             = (state_q != IDLE);
    assign overrun          = overrun_q;

endmodule
